// File: rtl/ft600_pkg.sv
// -----------------------------------------------------------------------------
// ft600_pkg
//   Shared constants and types for the FT600 245-synchronous-FIFO receive
//   front end.
//
//   Contents:
//     FT_DATA_W      width of the FT600 data bus (16 bits)
//     FT_BE_W        width of the FT600 byte-enable bus (2 bits)
//     FT_CNT_W       width of the received-byte counter shown on the LEDs
//     ft_state_t     receive FSM states {IDLE, OE, READ}
//     be_byte_count  number of valid bytes qualified by a byte-enable pattern
// -----------------------------------------------------------------------------
package ft600_pkg;

    localparam int FT_DATA_W = 16;
    localparam int FT_BE_W   = 2;
    localparam int FT_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        READ = 2'd2
    } ft_state_t;

    // Each BE bit qualifies one byte lane, so the byte count is the popcount
    // of the BE field, zero-extended to the counter width.
    function automatic logic [FT_CNT_W-1:0] be_byte_count(input logic [FT_BE_W-1:0] be);
        logic [1:0] w_sum;
        w_sum = {1'b0, be[1]} + {1'b0, be[0]};
        return {{(FT_CNT_W-2){1'b0}}, w_sum};
    endfunction

endpackage

// File: rtl/ft600_stream_receive_if.sv
// -----------------------------------------------------------------------------
// ft600_stream_receive_if
//   Control/handshake pins of the FT600 245-synchronous-FIFO interface.
//   The shared data and byte-enable buses are bidirectional and are kept as
//   plain inout ports on the top module.
//
//   Signals:
//     rxf_n    FT600 -> FPGA  low = FT600 RX FIFO holds data
//     txe_n    FT600 -> FPGA  low = FT600 TX FIFO has space
//     oe_n     FPGA -> FT600  low = FT600 drives the data bus
//     rd_n     FPGA -> FT600  low = pop one word per clock
//     wr_n     FPGA -> FT600  low = push one word per clock
//     resetn   FPGA -> FT600  chip reset, active low
//     wakeupn  FPGA -> FT600  wake-up request, active low
//
//   Modports:
//     master   the FT600 chip side (sources the FIFO status flags)
//     slave    the FPGA receiver side (sources the bus control strobes)
// -----------------------------------------------------------------------------
interface ft600_stream_receive_if;

    logic rxf_n;
    logic txe_n;
    logic oe_n;
    logic rd_n;
    logic wr_n;
    logic resetn;
    logic wakeupn;

    modport master (
        output rxf_n,
        output txe_n,
        input  oe_n,
        input  rd_n,
        input  wr_n,
        input  resetn,
        input  wakeupn
    );

    modport slave (
        input  rxf_n,
        input  txe_n,
        output oe_n,
        output rd_n,
        output wr_n,
        output resetn,
        output wakeupn
    );

endinterface

// File: rtl/ft600_rx_fsm.sv
// -----------------------------------------------------------------------------
// ft600_rx_fsm
//   Read-side handshake FSM for the FT600 245-synchronous FIFO. Drains every
//   word the FT600 offers using an OE_N turnaround cycle followed by RD_N
//   streaming, and captures each accepted word and its byte enables.
//
//   Ports:
//     i_clk       FT600-sourced clock, rising edge active
//     i_rst_n     asynchronous active-low reset
//     i_rxf_n     low = FT600 RX FIFO holds data
//     i_data      FT600 data bus (sampled only on accept)
//     i_be        FT600 byte enables (sampled only on accept)
//     o_oe_n      registered output enable to the FT600, active low
//     o_rd_n      registered read strobe to the FT600, active low
//     o_rx_valid  one-cycle pulse after each accepting edge
//     o_rx_data   last accepted word, valid while o_rx_valid is high
//     o_rx_be     byte enables of the last accepted word
// -----------------------------------------------------------------------------
module ft600_rx_fsm
    import ft600_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rxf_n,
    input  logic [FT_DATA_W-1:0] i_data,
    input  logic [FT_BE_W-1:0]   i_be,
    output logic                 o_oe_n,
    output logic                 o_rd_n,
    output logic                 o_rx_valid,
    output logic [FT_DATA_W-1:0] o_rx_data,
    output logic [FT_BE_W-1:0]   o_rx_be
);

    ft_state_t            r_state;
    logic                 r_oe_n;
    logic                 r_rd_n;
    logic                 r_rx_valid;
    logic [FT_DATA_W-1:0] r_rx_data;
    logic [FT_BE_W-1:0]   r_rx_be;
    logic                 w_accept;

    // A word is transferred on every edge where RD_N is already low (READ)
    // and the FT600 still reports data; the edge that sees RXF_N high ends
    // the burst without a transfer.
    assign w_accept = (r_state == READ) && !i_rxf_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_oe_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_accept;
            case (r_state)
                IDLE: begin
                    if (!i_rxf_n) begin
                        // Hand the bus to the FT600 one cycle before reading.
                        r_state <= OE;
                        r_oe_n  <= 1'b0;
                        r_rd_n  <= 1'b1;
                    end
                end
                OE: begin
                    if (!i_rxf_n) begin
                        r_state <= READ;
                        r_oe_n  <= 1'b0;
                        r_rd_n  <= 1'b0;
                    end else begin
                        // Data vanished during turnaround: release without reading.
                        r_state <= IDLE;
                        r_oe_n  <= 1'b1;
                        r_rd_n  <= 1'b1;
                    end
                end
                READ: begin
                    if (i_rxf_n) begin
                        r_state <= IDLE;
                        r_oe_n  <= 1'b1;
                        r_rd_n  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_oe_n  <= 1'b1;
                    r_rd_n  <= 1'b1;
                end
            endcase
        end
    end

    // Captured word is debug/datapath state only; it needs no reset because
    // o_rx_valid qualifies it.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_rx_data <= i_data;
            r_rx_be   <= i_be;
        end
    end

    assign o_oe_n     = r_oe_n;
    assign o_rd_n     = r_rd_n;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_rx_be    = r_rx_be;

endmodule

// File: rtl/ft600_stream_receive.sv
// -----------------------------------------------------------------------------
// ft600_stream_receive
//   Receive-only FT600 245-synchronous-FIFO front end. Drains every word the
//   FT600 offers and counts the valid bytes; the low nibble of the count is
//   shown on the board LEDs. The block never writes to the FT600 and never
//   drives the shared data or byte-enable buses.
//
//   Ports:
//     ftdi_clk   FT600-sourced clock (66/100 MHz), rising edge active
//     rst_n      asynchronous active-low reset
//     ftdi       FT600 control pins (slave modport): rxf_n/txe_n in,
//                oe_n/rd_n/wr_n/resetn/wakeupn out
//     ftdi_data  FT600 data bus, kept high-Z by this block
//     ftdi_be    FT600 byte enables, kept high-Z by this block;
//                be[0] qualifies data[7:0], be[1] qualifies data[15:8]
//     LED        received-byte count modulo 16
// -----------------------------------------------------------------------------
module ft600_stream_receive
    import ft600_pkg::*;
(
    input  logic                  ftdi_clk,
    input  logic                  rst_n,
    ft600_stream_receive_if.slave ftdi,
    inout  wire [FT_DATA_W-1:0]   ftdi_data,
    inout  wire [FT_BE_W-1:0]     ftdi_be,
    output logic [FT_CNT_W-1:0]   LED
);

    logic                 w_oe_n;
    logic                 w_rd_n;
    logic                 w_rx_valid;
    logic [FT_DATA_W-1:0] w_rx_data;
    logic [FT_BE_W-1:0]   w_rx_be;
    logic                 r_wr_n;
    logic                 r_wakeupn;
    logic [FT_CNT_W-1:0]  r_byte_cnt;
    logic                 w_unused_txe_n;

    // Receive-only: the FPGA side of both shared buses is permanently released.
    assign ftdi_data = {FT_DATA_W{1'bz}};
    assign ftdi_be   = {FT_BE_W{1'bz}};

    ft600_rx_fsm u_fsm (
        .i_clk      (ftdi_clk),
        .i_rst_n    (rst_n),
        .i_rxf_n    (ftdi.rxf_n),
        .i_data     (ftdi_data),
        .i_be       (ftdi_be),
        .o_oe_n     (w_oe_n),
        .o_rd_n     (w_rd_n),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_be    (w_rx_be)
    );

    // Write and wake-up strobes are never used but are still driven from
    // flops so every FT600 control output is glitch-free.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_n    <= 1'b1;
            r_wakeupn <= 1'b1;
        end else begin
            r_wr_n    <= 1'b1;
            r_wakeupn <= 1'b1;
        end
    end

    // Counter advances one clock after the accepting edge, using the BE of
    // the word captured there; it wraps naturally at 16.
    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
        end else if (w_rx_valid) begin
            r_byte_cnt <= r_byte_cnt + be_byte_count(w_rx_be);
        end
    end

    assign ftdi.oe_n    = w_oe_n;
    assign ftdi.rd_n    = w_rd_n;
    assign ftdi.wr_n    = r_wr_n;
    assign ftdi.wakeupn = r_wakeupn;
    assign ftdi.resetn  = rst_n;
    assign LED          = r_byte_cnt;

    // TX FIFO space is irrelevant to a receive-only block.
    assign w_unused_txe_n = ftdi.txe_n;

endmodule

// File: tb/tb_ft600_stream_receive.sv
module tb_ft600_stream_receive;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_data;
    logic [1:0]  tb_be;
    logic [3:0]  LED;
    wire  [15:0] ftdi_data;
    wire  [1:0]  ftdi_be;

    ft600_stream_receive_if ftdi_if ();

    // FT600 model: drives the bus only while the FPGA asserts OE_N.
    assign ftdi_data = (ftdi_if.oe_n == 1'b0) ? tb_data : 16'hzzzz;
    assign ftdi_be   = (ftdi_if.oe_n == 1'b0) ? tb_be   : 2'bzz;

    ft600_stream_receive dut (
        .ftdi_clk  (clk),
        .rst_n     (rst_n),
        .ftdi      (ftdi_if),
        .ftdi_data (ftdi_data),
        .ftdi_be   (ftdi_be),
        .LED       (LED)
    );

    int          n_vec;
    int          n_err;
    int          exp_cnt;
    bit          mon_en;
    logic [17:0] sb[$];
    logic [15:0] w_data[32];
    logic [1:0]  w_be[32];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        ftdi_if.txe_n = 1'b1;
        forever #7 ftdi_if.txe_n = ~ftdi_if.txe_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_bytes(input logic [1:0] be);
        case (be)
            2'b11:   return 2;
            2'b01:   return 1;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    // Scoreboard consumer: every captured word must match the oldest pushed one.
    always @(negedge clk) begin
        if (mon_en && dut.w_rx_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", sb.size(), 1);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                chk("rx_data", dut.w_rx_data, e[17:2]);
                chk("rx_be", dut.w_rx_be, e[1:0]);
            end
        end
    end

    // Called at a negedge. Offers n words from w_data/w_be, advancing to the
    // next word only after the FPGA pulled one (RD_N low at an edge).
    task automatic burst(input int n, input bit chk_lat, input string tag);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        ftdi_if.rxf_n = 1'b0;
        tb_data = w_data[0];
        tb_be   = w_be[0];
        while (idx < n && guard < 64) begin
            if (ftdi_if.rd_n == 1'b0) begin
                sb.push_back({w_data[idx], w_be[idx]});
                exp_cnt += ref_bytes(w_be[idx]);
                idx++;
            end
            @(negedge clk);
            guard++;
            if (chk_lat && guard == 1) begin
                chk({tag, "_oe_fall"}, ftdi_if.oe_n, 1'b0);
                chk({tag, "_rd_wait"}, ftdi_if.rd_n, 1'b1);
            end
            if (chk_lat && guard == 2)
                chk({tag, "_rd_fall"}, ftdi_if.rd_n, 1'b0);
            if (idx < n) begin
                tb_data = w_data[idx];
                tb_be   = w_be[idx];
            end
        end
        chk({tag, "_words"}, idx, n);
        chk({tag, "_rd_hold"}, ftdi_if.rd_n, 1'b0);
        ftdi_if.rxf_n = 1'b1;
        @(negedge clk);
        chk({tag, "_oe_rise"}, ftdi_if.oe_n, 1'b1);
        chk({tag, "_rd_rise"}, ftdi_if.rd_n, 1'b1);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 0;
        mon_en  = 1'b1;
        tb_data = 16'h0000;
        tb_be   = 2'b00;
        ftdi_if.rxf_n = 1'b1;
        rst_n = 1'b1;

        // Reset
        #1 rst_n = 1'b0;
        #12;
        chk("rst_oe_n", ftdi_if.oe_n, 1'b1);
        chk("rst_rd_n", ftdi_if.rd_n, 1'b1);
        chk("rst_wr_n", ftdi_if.wr_n, 1'b1);
        chk("rst_wakeupn", ftdi_if.wakeupn, 1'b1);
        chk("rst_resetn", ftdi_if.resetn, 1'b0);
        chk("rst_led", LED, 4'h0);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("resetn_pass", ftdi_if.resetn, 1'b1);

        // 16-word ASCII burst "0123456789abcdef" twice
        for (int k = 0; k < 16; k++) begin
            int c0;
            int c1;
            c0 = 2 * (k % 8);
            c1 = c0 + 1;
            w_data[k][7:0]  = (c0 < 10) ? 8'(8'h30 + c0) : 8'(8'h61 + c0 - 10);
            w_data[k][15:8] = (c1 < 10) ? 8'(8'h30 + c1) : 8'(8'h61 + c1 - 10);
            w_be[k] = 2'b11;
        end
        chk("ascii_first_word", w_data[0], 16'h3130);
        burst(16, 1'b1, "burst16");
        chk("burst16_led", LED, 4'(exp_cnt));
        chk("burst16_led_abs", LED, 4'h0);

        // Partial byte enables
        w_data[0] = 16'h1122; w_be[0] = 2'b01;
        w_data[1] = 16'h3344; w_be[1] = 2'b10;
        w_data[2] = 16'h5566; w_be[2] = 2'b11;
        burst(3, 1'b0, "partial");
        chk("partial_led", LED, 4'(exp_cnt));
        chk("partial_led_abs", LED, 4'h4);

        // Short burst: RXF_N deasserted during the OE turnaround
        ftdi_if.rxf_n = 1'b0;
        @(negedge clk);
        chk("short_oe_fall", ftdi_if.oe_n, 1'b0);
        chk("short_rd_idle", ftdi_if.rd_n, 1'b1);
        ftdi_if.rxf_n = 1'b1;
        @(negedge clk);
        chk("short_oe_rise", ftdi_if.oe_n, 1'b1);
        chk("short_rd_never", ftdi_if.rd_n, 1'b1);
        repeat (2) @(negedge clk);
        chk("short_rd_later", ftdi_if.rd_n, 1'b1);
        chk("short_led", LED, 4'h4);

        // Reset in the middle of a burst
        mon_en = 1'b0;
        tb_data = 16'hA5A5;
        tb_be   = 2'b11;
        ftdi_if.rxf_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_in_read", ftdi_if.rd_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oe_n", ftdi_if.oe_n, 1'b1);
        chk("midrst_rd_n", ftdi_if.rd_n, 1'b1);
        chk("midrst_led", LED, 4'h0);
        exp_cnt = 0;
        sb.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        w_data[0] = 16'hBEEF; w_be[0] = 2'b00;
        w_data[1] = 16'hCAFE; w_be[1] = 2'b00;
        burst(2, 1'b1, "postrst");
        chk("postrst_led", LED, 4'h0);

        // Wrap: 9 full words = 18 bytes
        for (int k = 0; k < 9; k++) begin
            w_data[k] = 16'($urandom);
            w_be[k]   = 2'b11;
        end
        burst(9, 1'b0, "wrap");
        chk("wrap_led", LED, 4'(exp_cnt));
        chk("wrap_led_abs", LED, 4'h2);
        chk("wrap_last_word", dut.w_rx_data, w_data[8]);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_wr_n", ftdi_if.wr_n, 1'b1);
        chk("idle_wakeupn", ftdi_if.wakeupn, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
